// File: rtl/uart_tx_arb_if.sv
// Requester byte streams and uart TX handshake shared by uart_tx_arb and its environment.
interface uart_tx_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   abort;
    logic                 uart_tx_latch;
    logic [7:0]           uart_tx_data;
    logic                 uart_tx_empty;

    // master: requesters plus the uart; slave: the arbiter itself
    modport master (
        output req, req_data, req_last, uart_tx_empty,
        input  ack, abort, uart_tx_latch, uart_tx_data
    );

    modport slave (
        input  req, req_data, req_last, uart_tx_empty,
        output ack, abort, uart_tx_latch, uart_tx_data
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Message-locked round-robin sharing of one uart TX channel among NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to revoke a lock whose owner stalls for TIMEOUT_CYCLES.
module uart_tx_arb #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic            clk,
    input  logic            reset_n,
    uart_tx_arb_if.slave    bus,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id
);

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_q, rr_d, grant_id_d;
    logic                 grant_valid_d;
    logic                 latch_q, latch_d;
    logic [7:0]           data_q, data_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 last_q, last_d;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic                 sel_req, sel_last;
    logic [7:0]           sel_data;
    logic                 pick_found;
    logic [ID_W-1:0]      pick_id;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]          stall_q, stall_d;
    logic [NUM_REQ-1:0]   abort_q, abort_d;
`endif

    // Signals of the requester currently holding (or last holding) the grant
    always_comb begin
        sel_onehot = '0;
        sel_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_onehot[i] = (grant_id == ID_W'(i));
            if (sel_onehot[i]) sel_data = bus.req_data[8*i +: 8];
        end
        sel_req  = |(bus.req & sel_onehot);
        sel_last = |(bus.req_last & sel_onehot);
    end

    // First requester after the rr pointer, wrapping at NUM_REQ-1
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!pick_found && bus.req[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        grant_id_d    = grant_id;
        grant_valid_d = grant_valid;
        data_d        = data_q;
        latch_d       = 1'b0;
        ack_d         = '0;
        last_d        = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        stall_d       = '0;
        abort_d       = '0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (sel_req && bus.uart_tx_empty) begin
                    data_d  = sel_data;
                    latch_d = 1'b1;
                    ack_d   = sel_onehot;
                    last_d  = sel_last;
                    state_d = GUARD;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (!sel_req) begin
                    if (stall_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        abort_d       = sel_onehot;
                        grant_valid_d = 1'b0;
                        rr_d          = grant_id;
                        state_d       = IDLE;
                    end else begin
                        stall_d = stall_q + 16'd1;
                    end
                end else begin
                    stall_d = stall_q;
                end
`endif
            end
            // One idle cycle lets the uart drop tx_empty before the next byte is considered
            GUARD: begin
                if (last_q) begin
                    grant_valid_d = 1'b0;
                    rr_d          = grant_id;
                    state_d       = IDLE;
                end else begin
                    state_d = GRANT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_q        <= ID_W'(NUM_REQ - 1);
            grant_id    <= '0;
            grant_valid <= 1'b0;
            data_q      <= 8'h00;
            latch_q     <= 1'b0;
            ack_q       <= '0;
            last_q      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            stall_q     <= '0;
            abort_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_id    <= grant_id_d;
            grant_valid <= grant_valid_d;
            data_q      <= data_d;
            latch_q     <= latch_d;
            ack_q       <= ack_d;
            last_q      <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
            stall_q     <= stall_d;
            abort_q     <= abort_d;
`endif
        end
    end

    assign bus.uart_tx_latch = latch_q;
    assign bus.uart_tx_data  = data_q;
    assign bus.ack           = ack_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.abort         = abort_q;
`else
    assign bus.abort         = '0;
`endif

endmodule
